// File: rtl/sipo_frame_controller.sv
// Serial-in/parallel-out frame controller: shifts LSB-first bits into words,
// hands each word over valid/ready and flags overrun when the consumer lags.
module sipo_frame_controller #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned WORDS_PER_FRAME = 4
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    input  logic                  Abort_In,
    input  logic                  Serial_Data_In,
    input  logic                  Bit_Valid_In,
    input  logic                  Word_Ready_In,
    output logic [DATA_WIDTH-1:0] Word_Out,
    output logic                  Word_Valid_Out,
    output logic                  Frame_Done_Out,
    output logic                  Overrun_Out,
    output logic                  Busy_Out
);

    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam int unsigned WW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [BW-1:0]         bit_cnt;
    logic [WW-1:0]         word_cnt;
    logic                  word_end;
    logic                  load;

    // Abort outranks completion, so a word never ends on an aborting cycle.
    always_comb begin
        shifted  = {Serial_Data_In, shift_reg[DATA_WIDTH-1:1]};
        word_end = (state == SHIFT) && !Abort_In && Bit_Valid_In &&
                   (bit_cnt == BW'(DATA_WIDTH - 1));
        load     = word_end && (!Word_Valid_Out || Word_Ready_In);
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            word_cnt       <= '0;
            Word_Out       <= '0;
            Word_Valid_Out <= 1'b0;
            Frame_Done_Out <= 1'b0;
            Overrun_Out    <= 1'b0;
            Busy_Out       <= 1'b0;
        end else begin
            Frame_Done_Out <= 1'b0;

            // Handshake runs in every state so a pending word survives IDLE.
            if (load) begin
                Word_Out       <= shifted;
                Word_Valid_Out <= 1'b1;
            end else if (Word_Ready_In) begin
                Word_Valid_Out <= 1'b0;
            end

            if (word_end && !load) begin
                Overrun_Out <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (Start_In) begin
                        state       <= SHIFT;
                        Busy_Out    <= 1'b1;
                        bit_cnt     <= '0;
                        word_cnt    <= '0;
                        shift_reg   <= '0;
                        Overrun_Out <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (Abort_In) begin
                        state    <= IDLE;
                        Busy_Out <= 1'b0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end else if (Bit_Valid_In) begin
                        shift_reg <= shifted;
                        if (word_end) begin
                            bit_cnt <= '0;
                            if (word_cnt == WW'(WORDS_PER_FRAME - 1)) begin
                                word_cnt       <= '0;
                                state          <= DONE;
                                Busy_Out       <= 1'b0;
                                Frame_Done_Out <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sipo_frame_controller.md
# sipo_frame_controller

Sequencing controller for a 16-bit serial-in-parallel-out capture path. It owns the shift register, a bit counter and a word counter. It frames a burst of serial bits into a fixed number of parallel words and hands each word to a downstream consumer over a valid/ready handshake. It sits between a serial receive front end, which supplies a bit plus a bit strobe, and any parallel consumer. Overrun is flagged when the consumer falls behind.

## Interface
- DATA_WIDTH, default 16: bits per word, must be ≥ 2.
- WORDS_PER_FRAME, default 4: words per frame, must be ≥ 1.
- Clk_In  input  1  single clock; all state updates on rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Start_In  input  1  begin a frame; honoured only in IDLE.
- Abort_In  input  1  abandon current frame; return to IDLE.
- Serial_Data_In  input  1  serial data bit.
- Bit_Valid_In  input  1  Serial_Data_In is valid this cycle.
- Word_Ready_In  input  1  consumer accepts Word_Out this cycle.
- Word_Out  output  DATA_WIDTH  last completed parallel word.
- Word_Valid_Out  output  1  Word_Out holds an unaccepted word.
- Frame_Done_Out  output  1  one-cycle pulse at frame completion.
- Overrun_Out  output  1  sticky; a word was dropped.
- Busy_Out  output  1  state is SHIFT.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Reset values:** state IDLE, shift register 0, bit count 0, word count 0, Word_Out 0, Word_Valid_Out 0, Frame_Done_Out 0, Overrun_Out 0, Busy_Out 0.
- **IDLE:**
  - Bit_Valid_In is ignored.
  - Start_In=1 moves to SHIFT, clears bit count, word count, shift register and Overrun_Out.
  - A pending Word_Valid_Out is retained.
- **SHIFT:**
  - Each cycle with Bit_Valid_In=1 shifts the register right.
  - The new bit enters bit [DATA_WIDTH-1]; bit [i] takes bit [i+1]; bit [0] is discarded.
  - Result: the first received bit of a word ends in bit 0 (LSB-first serial).
  - Bit count increments per accepted bit.
- **Word completion** (the DATA_WIDTH-th accepted bit):
  - The shifted value, including the current bit, is the completed word.
  - Bit count wraps to 0 and word count increments.
  - If Word_Valid_Out=0, or Word_Ready_In=1 in the same cycle: Word_Out ← completed word, Word_Valid_Out ← 1.
  - Otherwise the word is dropped: Word_Out is unchanged and Overrun_Out ← 1.
  - Dropped words still count toward the frame.
- **Frame end:** completion of word number WORDS_PER_FRAME moves to DONE.
- **DONE:** lasts one cycle; Frame_Done_Out=1, bits are ignored; next state IDLE.
- **Handshake:**
  - Word_Valid_Out clears on Word_Ready_In=1 unless a new word loads in that same cycle, in which case it stays 1.
  - Word_Ready_In while Word_Valid_Out=0 has no effect.
- **Abort_In:**
  - In SHIFT: moves to IDLE, clears bit count and word count; the partial word is discarded. Word_Out, Word_Valid_Out and Overrun_Out are unchanged. No Frame_Done_Out.
  - Priority: Abort_In beats any bit or word completion in the same cycle.
  - In IDLE or DONE: no effect.
- **Start_In** in SHIFT or DONE is ignored.
- **Reset_In** asserted mid-frame forces all reset values immediately; no completion or done pulse is produced.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Word_Out and Word_Valid_Out update one edge after sampling, i.e. visible the cycle after the edge that captured the last bit.
- Frame_Done_Out is high for exactly the one cycle following the edge capturing the final bit of the final word. Word_Valid_Out rises in that same cycle (unless the word was dropped).
- Busy_Out rises the cycle after Start_In is sampled and falls when DONE or IDLE is entered.
- Minimum frame duration: 1 (start) + DATA_WIDTH×WORDS_PER_FRAME bit cycles + 1 (DONE).
- Back-to-back frames: Start_In is accepted on the first IDLE cycle after DONE.
- Bit_Valid_In gaps of any length within SHIFT are tolerated; the bit count holds.

## Test plan
- **Reset and single word:** Reset → all outputs 0. Start, then feed 0xA5C3 LSB-first as 16 consecutive strobes, with Word_Ready_In=1 → Word_Out=0xA5C3 and Word_Valid_Out=1 for one cycle, one cycle after the 16th bit.
- **Full frame:** Words 0x0001, 0x8000, 0xFFFF, 0x1234 with Word_Ready_In held high → four valid words in order; Frame_Done_Out pulses once, coincident with Word_Valid_Out for 0x1234; Busy_Out falls and Overrun_Out=0.
- **Overrun:** Word_Ready_In=0 while words 0x1111 then 0x2222 complete → Word_Out stays 0x1111 and Overrun_Out=1 (sticky). The frame still ends after 4 completions. Next Start_In clears Overrun_Out.
- **Simultaneous accept and load:** Word_Ready_In=1 exactly on the edge completing word 2 while word 1 is pending → Word_Out=word 2, Word_Valid_Out stays 1, no overrun.
- **Abort and gaps:** Random Bit_Valid_In gaps, then Abort_In after 7 bits → IDLE, no Frame_Done_Out. A fresh frame then captures 0xBEEF correctly, with no leftover bits.
- **Async reset mid-frame:** Reset_In pulsed between clock edges at bit 9 of word 3 → all outputs 0 immediately. Start_In, bits and Word_Ready_In issued in IDLE before a Start_In have no effect.
